// File: rtl/muldiv_seq_pkg.sv
// pipes: shared execute-stage types for the multiply/divide sequencer.
//   alufunc_t       ALU function codes seen by the execute stage
//   muldiv_state_t  sequencer FSM states
//   MULDIV_ITER_*   iteration counts for 64-bit and word operations
//   is_muldiv()     true for the codes the sequencer accepts
package pipes;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MULT, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU
    } alufunc_t;

    typedef enum logic [2:0] {
        IDLE, MUL, DIV, FIX, DONE
    } muldiv_state_t;

    localparam int MULDIV_ITER_64 = 64;
    localparam int MULDIV_ITER_32 = 32;

    function automatic logic is_muldiv(input alufunc_t f);
        return f inside {ALU_MULT, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_seq_iter.sv
// muldiv_iter: shift-add multiply / restoring divide datapath registers.
//   clk, reset    clock, async active-high reset
//   i_load        capture initial multiplicand/divisor and shift register
//   i_mcand       multiplicand (mul) or divisor magnitude (div)
//   i_sr          multiplier (mul) or left-aligned dividend magnitude (div)
//   i_mul_step    one shift-add step
//   i_div_step    one restoring-divide step
//   o_prod        low XLEN bits of the running product
//   o_quot        quotient (shift register after the last divide step)
//   o_rem         partial remainder
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0] i_sr,
    input  logic            i_mul_step,
    input  logic            i_div_step,
    output logic [XLEN-1:0] o_prod,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_sr;
    logic [XLEN-1:0] r_mcand;

    // Remainder stays below the divisor, so the shifted value needs one extra
    // bit; the top bit of the difference is the borrow.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {r_rem, r_sr[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_mcand};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_sr    <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_sr    <= i_sr;
            r_mcand <= i_mcand;
        end else if (i_mul_step) begin
            r_acc   <= r_acc + (r_sr[0] ? r_mcand : '0);
            r_mcand <= r_mcand << 1;
            r_sr    <= r_sr >> 1;
        end else if (i_div_step) begin
            if (!w_diff[XLEN]) begin
                r_rem <= w_diff[XLEN-1:0];
                r_sr  <= {r_sr[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[XLEN-1:0];
                r_sr  <= {r_sr[XLEN-2:0], 1'b0};
            end
        end
    end

    assign o_prod = r_acc;
    assign o_quot = r_sr;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer for the execute stage.
//   clk, reset    clock, async active-high reset
//   start_valid   execute stage holds a mul/div instruction
//   func          ALU_MULT/DIV/REM/DIVU/REMU (others ignored)
//   is_word       W form: 32-bit operands, sign-extended 32-bit result
//   a, b          rs1 / rs2
//   flush         kill the in-flight operation
//   busy          pipeline stall request (combinational)
//   done          one-cycle result-valid pulse
//   result        product, quotient or remainder
module muldiv_seq
    import pipes::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    input  alufunc_t        func,
    input  logic            is_word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;

    muldiv_state_t   r_state, w_state_nxt;
    logic [6:0]      r_cnt;
    alufunc_t        r_func;
    logic            r_word;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    // ---- operand prep (input side, used on the accept edge) ----
    logic            w_is_mul, w_is_rem, w_unsigned, w_signed_div;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
    logic            w_sa, w_sb, w_b_zero, w_ovf, w_special, w_accept;
    logic [XLEN-1:0] w_spec_res;

    assign w_is_mul     = (func == ALU_MULT);
    assign w_is_rem     = (func == ALU_REM) || (func == ALU_REMU);
    assign w_unsigned   = (func == ALU_DIVU) || (func == ALU_REMU);
    assign w_signed_div = (func == ALU_DIV) || (func == ALU_REM);

    assign w_a_ext = !is_word  ? a :
                     w_unsigned ? {{HALF{1'b0}}, a[HALF-1:0]} : {{HALF{a[HALF-1]}}, a[HALF-1:0]};
    assign w_b_ext = !is_word  ? b :
                     w_unsigned ? {{HALF{1'b0}}, b[HALF-1:0]} : {{HALF{b[HALF-1]}}, b[HALF-1:0]};

    assign w_sa    = w_signed_div & w_a_ext[XLEN-1];
    assign w_sb    = w_signed_div & w_b_ext[XLEN-1];
    assign w_a_mag = w_sa ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_sb ? -w_b_ext : w_b_ext;

    // Most-negative value at the operation width, as it looks after sign extension.
    assign w_min = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

    assign w_b_zero   = !w_is_mul && (w_b_ext == '0);
    assign w_ovf      = w_signed_div && (w_a_ext == w_min) && (&w_b_ext);
    assign w_special  = w_b_zero | w_ovf;
    assign w_spec_res = w_b_zero ? (w_is_rem ? w_a_ext : '1)
                                 : (w_is_rem ? '0 : w_a_ext);

    assign w_accept = (r_state == IDLE) && start_valid && !flush && is_muldiv(func);

    // ---- datapath ----
    logic [XLEN-1:0] w_prod, w_quot, w_rem;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept && !w_special),
        .i_mcand    (w_is_mul ? w_a_ext : w_b_mag),
        // Word divides run 32 steps, so the dividend is left-aligned.
        .i_sr       (w_is_mul ? w_b_ext : (is_word ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag)),
        .i_mul_step (r_state == MUL),
        .i_div_step (r_state == DIV),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // ---- FIX: sign correction and W sign-extension ----
    logic [XLEN-1:0] w_raw, w_fix;

    always_comb begin
        w_raw = w_prod;
        case (r_func)
            ALU_DIV, ALU_DIVU: w_raw = r_neg_q ? -w_quot : w_quot;
            ALU_REM, ALU_REMU: w_raw = r_neg_r ? -w_rem : w_rem;
            default:           w_raw = w_prod;
        endcase
    end

    assign w_fix = r_word ? {{HALF{w_raw[HALF-1]}}, w_raw[HALF-1:0]} : w_raw;

    // ---- FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_special ? DONE : (w_is_mul ? MUL : DIV);
            MUL, DIV: begin
                if (flush)           w_state_nxt = IDLE;
                else if (r_cnt == 1) w_state_nxt = FIX;
            end
            FIX:  w_state_nxt = flush ? IDLE : DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_func   <= ALU_ADD;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= is_word ? 7'(MULDIV_ITER_32) : 7'(MULDIV_ITER_64);
                r_func  <= func;
                r_word  <= is_word;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
            end else if ((r_state == MUL || r_state == DIV) && r_cnt != '0) begin
                r_cnt <= r_cnt - 7'd1;
            end

            if (w_accept && w_special)        r_result <= w_spec_res;
            else if (r_state == FIX && !flush) r_result <= w_fix;
        end
    end

    assign busy   = w_accept || (r_state == MUL) || (r_state == DIV) || (r_state == FIX);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the execute stage. It accepts one ALU_MULT/ALU_DIV/ALU_REM/ALU_DIVU/ALU_REMU operation, in 64-bit or word (W) form, and runs it on an iterative shift-add / restoring-divide datapath. While the operation is in flight it holds the pipeline through `busy`. It returns a single-cycle `done` pulse together with the 64-bit `result`, which the execute stage places into `excute_data_t.result`.

## Interface
Parameters:
- XLEN, 64, operand and result width; only 64 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  execute stage holds a valid mul/div instruction.
- func  in  alufunc_t  one of ALU_MULT, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU; any other value is ignored.
- is_word  in  1  operation is the W form (opcode F7_ALUW).
- a, b  in  64  rs1 and rs2 values (`decode_data_t.srca` / `srcb`).
- flush  in  1  kill the in-flight operation.
- busy  out  1  stall request to the pipeline.
- done  out  1  result valid; high for one cycle.
- result  out  64  product, quotient or remainder.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. Reset drives the state to IDLE, `done` to 0, `result` to 0, and clears the counter and accumulators.
- Accept: in IDLE with start_valid=1, flush=0 and func a mul/div code, the operands and op are latched at the clock edge. Operations are accepted only in IDLE.
- Operand prep:
  - W forms use a[31:0] and b[31:0]. These are sign-extended for MULT/DIV/REM and zero-extended for DIVU/REMU.
  - Signed divide works on magnitudes; the two sign bits are latched.
- Iteration count: 64 for 64-bit ops, 32 for W ops. The 7-bit counter is loaded on accept and decremented each cycle in MUL or DIV.
  - MUL does one shift-add step per cycle and keeps the low 64 product bits. MULT is signedness-agnostic.
  - DIV does one restoring step per cycle, producing one quotient bit and a partial remainder.
- Counter reaching 0 moves the state to FIX. FIX applies:
  - quotient negation when the operand signs differ;
  - a remainder that takes the dividend's sign;
  - for W ops, sign-extension of bit 31. This applies to DIVUW/REMUW too.
- FIX → DONE, with `result` registered. DONE → IDLE unconditionally.
- Special cases skip iteration and go IDLE → DONE directly:
  - b (or b[31:0] for W) = 0 → quotient is all-ones and remainder is the prepared dividend.
  - Signed overflow (most-negative / −1, at width 64 or 32) → quotient is the dividend, remainder is 0.
- `busy` = (IDLE & start_valid & !flush & mul/div func) | MUL | DIV | FIX. It is combinational and low in DONE, so the pipeline advances on the DONE edge and captures `result`.
- `done` = state==DONE.
- Flush in any state → IDLE at the next edge. In that case `done` is not asserted and `result` keeps its old value. Flush in DONE is harmless because `done` is still seen.
- A start_valid still high in the DONE cycle belongs to the same instruction and is not re-accepted. The next acceptance is possible in the following IDLE cycle.

## Timing
- The acceptance cycle is cycle 0.
- 64-bit ops: MUL/DIV in cycles 1–64, FIX in cycle 65, done=1 in cycle 66.
- W ops: done=1 in cycle 34.
- Special cases: done=1 in cycle 1.
- `busy` is high from cycle 0 up to, but not including, the done cycle.
- `result` is stable from the done cycle until the next op reaches FIX or a special-case DONE.
- Asynchronous reset mid-operation gives immediate IDLE, busy=0 (when start_valid=0) and done=0.

## Structure
- Shared package `pipes` holds:
  - `muldiv_state_t` (IDLE, MUL, DIV, FIX, DONE);
  - `MULDIV_ITER_64 = 64` and `MULDIV_ITER_32 = 32`;
  - a helper for testing whether an `alufunc_t` is a mul/div code.
- Sub-module `muldiv_iter` holds the shift/add/subtract datapath registers: accumulator, partial remainder and quotient/multiplier shift register. `muldiv_seq` holds the FSM, counter, special-case detection and FIX.

## Test plan
- MULT, a=3, b=−5 (0xFFFF_FFFF_FFFF_FFFB) → busy cycles 0–65, done in cycle 66, result=0xFFFF_FFFF_FFFF_FFF1.
- DIV, a=−7, b=2 → result=−3. REM with the same operands → result=−1. REMU, a=7, b=0 → result=7 with done in cycle 1.
- DIVW, a=0x0000_0001_8000_0000, b=0xFFFF_FFFF → overflow case, result=0xFFFF_FFFF_8000_0000 with done in cycle 1.
- DIVUW, a=0xFFFF_FFFE, b=1 → done in cycle 34, result=0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- Flush at cycle 20 of a DIV → IDLE at cycle 21, no done pulse, result unchanged. A new MULT started in cycle 22 completes normally.
- Reset asserted mid-MUL → outputs at 0 immediately. Back-to-back ops with start_valid held through DONE produce exactly one done per instruction.
